alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
// Sequences operations onto the shared combinational 8-bit ALU (ADD/SUB/DIV/MUL, 16-bit result).
// Accepts one operation request at a time over a valid/ready handshake.
// Registers and drives the ALU operands/opcode, waits a fixed settle time, then captures the result.
// Returns the result over a second valid/ready handshake. Sits between the button/UART front end and the ALU.
// Supports chaining: A operand taken from the previous good result. Flags illegal operations.
// PARAMETERS
// WIDTH          8   operand width; ALU result width is 2*WIDTH
// SETTLE_CYCLES  2   clock edges from accept to result capture; legal range 1..15
// PORTS
// hz100          in   1          system clock
// reset          in   1          synchronous active-high reset
// req_valid      in   1          request present
// req_ready      out  1          sequencer can accept (high only in IDLE)
// req_opcode     in   4          0001 ADD, 0010 SUB, 0011 DIV, 0100 MUL
// req_a          in   WIDTH      operand A (ignored when req_chain=1)
// req_b          in   WIDTH      operand B
// req_chain      in   1          1: A = last_result[WIDTH-1:0]
// alu_a          out  WIDTH      registered operand to ALU valA
// alu_b          out  WIDTH      registered operand to ALU valB
// alu_opcode     out  4          registered opcode to ALU
// alu_result     in   2*WIDTH    ALU combinational result
// rsp_valid      out  1          response present
// rsp_ready      in   1          consumer takes response
// rsp_result     out  2*WIDTH    captured result (0 when rsp_err)
// rsp_err        out  1          DIV with B==0, or opcode not in {1,2,3,4}
// busy           out  1          high in SETTLE or RESP
// op_count       out  8          completed-response counter, wraps 255->0
// BEHAVIOUR
// - Reset, synchronous, at an edge with reset=1:
//   - state=IDLE; all outputs 0 except req_ready=1.
//   - last_result=0; any in-flight op is discarded with no response.
// - FSM IDLE -> SETTLE -> RESP -> IDLE.
//   - IDLE: req_ready=1. At edge E0 with req_valid=1:
//     - load alu_a/alu_b/alu_opcode; alu_a = chain ? last_result[WIDTH-1:0] : req_a.
//     - set cnt=0; go to SETTLE.
//   - SETTLE: cnt increments each edge. At the edge where cnt==SETTLE_CYCLES-1:
//     - capture into rsp_result/rsp_err; go to RESP.
//     - So rsp_valid rises at edge E0+SETTLE_CYCLES.
//   - RESP: rsp_valid=1; rsp_result and rsp_err stay stable until the handshake.
//     - At an edge with rsp_ready=1: rsp_valid<=0, op_count+1, go to IDLE.
//     - req_ready is high again the cycle after that edge. No accept/return overlap.
// - alu_* outputs hold their last values in IDLE; they are not cleared after an op.
// - Error ops still take the full settle latency. They return rsp_result=0, rsp_err=1.
//   - Error ops do not update last_result. They do count in op_count.
// - Good ops (rsp_err=0): last_result <= alu_result at capture.
// - Arithmetic is the ALU's own; results pass through unmodified at 2*WIDTH bits.
//   - SUB underflow is two's-complement wrap, e.g. 3-5 -> 16'hFFFE, rsp_err=0.
// - Chain with no prior good result since reset uses A=0.
// - req_valid while busy is ignored (req_ready=0). The requester holds its request.
// - Reset asserted in the same cycle as a request or response handshake: reset wins.
//   - Request not accepted, op_count unchanged.
// TESTING
// - ADD: A=8'h12, B=8'h34, op=0001 -> rsp_valid at E0+2, rsp_result=16'h0046, rsp_err=0.
// - MUL then chain:
//   - A=8'hFF, B=8'hFF, op=0100 -> 16'hFE01.
//   - Next chain=1, B=8'h02, op=0001 -> alu_a=8'h01, result 16'h0003.
// - Errors:
//   - DIV A=8'h10, B=0 -> rsp_err=1, result 0; next chained op uses the prior good result.
//   - op=4'b1111 -> rsp_err=1.
// - Backpressure: rsp_ready=0 for 10 cycles -> rsp_valid/rsp_result stable, req_ready=0, second req not taken.
// - Reset during SETTLE -> no rsp_valid ever; req_ready=1, op_count=0, last_result=0 after reset.
// - 256 completed ops -> op_count returns to 8'h00. SUB 3-5 -> 16'hFFFE, rsp_err=0.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_sequencer_if
//  Description : Bundles the request, ALU and response signals of the ALU
//                operation sequencer.
//                master : front end / consumer / ALU side (testbench, glue)
//                slave  : the sequencer itself
//  Signals     : req_*  request handshake and operands
//                alu_*  registered ALU operands/opcode and ALU result
//                rsp_*  response handshake, result and error flag
//                busy, op_count  status
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_op_sequencer_if #(
   parameter int WIDTH = 8
);
   logic                 req_valid;
   logic                 req_ready;
   logic [3:0]           req_opcode;
   logic [WIDTH-1:0]     req_a;
   logic [WIDTH-1:0]     req_b;
   logic                 req_chain;

   logic [WIDTH-1:0]     alu_a;
   logic [WIDTH-1:0]     alu_b;
   logic [3:0]           alu_opcode;
   logic [2*WIDTH-1:0]   alu_result;

   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [2*WIDTH-1:0]   rsp_result;
   logic                 rsp_err;

   logic                 busy;
   logic [7:0]           op_count;

   modport slave (
      input  req_valid, req_opcode, req_a, req_b, req_chain,
      input  alu_result, rsp_ready,
      output req_ready, alu_a, alu_b, alu_opcode,
      output rsp_valid, rsp_result, rsp_err, busy, op_count
   );

   modport master (
      output req_valid, req_opcode, req_a, req_b, req_chain,
      output alu_result, rsp_ready,
      input  req_ready, alu_a, alu_b, alu_opcode,
      input  rsp_valid, rsp_result, rsp_err, busy, op_count
   );
endinterface
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_sequencer
//  Description : Issues one operation at a time to a shared combinational
//                ALU. A request is accepted in IDLE, its operands/opcode are
//                registered onto the ALU, the result is captured after
//                SETTLE_CYCLES edges and returned over a response handshake.
//                Supports chaining (A = low half of the last good result) and
//                flags illegal operations (DIV by zero, unknown opcode).
//  Ports       : hz100  system clock
//                reset  synchronous active-high reset
//                bus    alu_op_sequencer_if.slave (request/ALU/response/status)
//  Parameters  : WIDTH          operand width, result is 2*WIDTH
//                SETTLE_CYCLES  edges from accept to capture, legal 1..15
//  Revision    : 1.0  initial release
// ============================================================================
module alu_op_sequencer #(
   parameter int WIDTH         = 8,
   parameter int SETTLE_CYCLES = 2
) (
   input  wire logic           hz100,
   input  wire logic           reset,
   alu_op_sequencer_if.slave   bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   localparam logic [3:0] c_op_add     = 4'b0001;
   localparam logic [3:0] c_op_sub     = 4'b0010;
   localparam logic [3:0] c_op_div     = 4'b0011;
   localparam logic [3:0] c_op_mul     = 4'b0100;
   localparam logic [3:0] c_settle_end = 4'(SETTLE_CYCLES - 1);

   state_t               state_q,      state_d;
   logic [3:0]           cnt_q,        cnt_d;
   logic [WIDTH-1:0]     alu_a_q,      alu_a_d;
   logic [WIDTH-1:0]     alu_b_q,      alu_b_d;
   logic [3:0]           alu_opcode_q, alu_opcode_d;
   logic [2*WIDTH-1:0]   last_result_q, last_result_d;
   logic [2*WIDTH-1:0]   rsp_result_q, rsp_result_d;
   logic                 rsp_err_q,    rsp_err_d;
   logic                 rsp_valid_q,  rsp_valid_d;
   logic                 req_ready_q,  req_ready_d;
   logic                 busy_q,       busy_d;
   logic [7:0]           op_count_q,   op_count_d;

   // Error is judged on the registered opcode/operand actually driven onto
   // the ALU, so it always matches what the ALU was asked to compute.
   logic w_op_err;
   always_comb begin
      w_op_err = 1'b0;
      case (alu_opcode_q)
         c_op_add, c_op_sub, c_op_mul: w_op_err = 1'b0;
         c_op_div:                     w_op_err = (alu_b_q == '0);
         default:                      w_op_err = 1'b1;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      alu_a_d       = alu_a_q;
      alu_b_d       = alu_b_q;
      alu_opcode_d  = alu_opcode_q;
      last_result_d = last_result_q;
      rsp_result_d  = rsp_result_q;
      rsp_err_d     = rsp_err_q;
      rsp_valid_d   = rsp_valid_q;
      req_ready_d   = req_ready_q;
      busy_d        = busy_q;
      op_count_d    = op_count_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               alu_a_d      = bus.req_chain ? last_result_q[WIDTH-1:0] : bus.req_a;
               alu_b_d      = bus.req_b;
               alu_opcode_d = bus.req_opcode;
               cnt_d        = 4'd0;
               req_ready_d  = 1'b0;
               busy_d       = 1'b1;
               state_d      = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == c_settle_end) begin
               rsp_err_d    = w_op_err;
               rsp_result_d = w_op_err ? '0 : bus.alu_result;
               // Only good results feed the chain operand.
               if (!w_op_err) begin
                  last_result_d = bus.alu_result;
               end
               rsp_valid_d  = 1'b1;
               state_d      = ST_RESP;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               op_count_d  = op_count_q + 8'd1;
               req_ready_d = 1'b1;
               busy_d      = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            rsp_valid_d = 1'b0;
            req_ready_d = 1'b1;
            busy_d      = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge hz100) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         cnt_q         <= 4'd0;
         alu_a_q       <= '0;
         alu_b_q       <= '0;
         alu_opcode_q  <= 4'd0;
         last_result_q <= '0;
         rsp_result_q  <= '0;
         rsp_err_q     <= 1'b0;
         rsp_valid_q   <= 1'b0;
         req_ready_q   <= 1'b1;
         busy_q        <= 1'b0;
         op_count_q    <= 8'd0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         alu_a_q       <= alu_a_d;
         alu_b_q       <= alu_b_d;
         alu_opcode_q  <= alu_opcode_d;
         last_result_q <= last_result_d;
         rsp_result_q  <= rsp_result_d;
         rsp_err_q     <= rsp_err_d;
         rsp_valid_q   <= rsp_valid_d;
         req_ready_q   <= req_ready_d;
         busy_q        <= busy_d;
         op_count_q    <= op_count_d;
      end
   end

   assign bus.req_ready  = req_ready_q;
   assign bus.alu_a      = alu_a_q;
   assign bus.alu_b      = alu_b_q;
   assign bus.alu_opcode = alu_opcode_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_result = rsp_result_q;
   assign bus.rsp_err    = rsp_err_q;
   assign bus.busy       = busy_q;
   assign bus.op_count   = op_count_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_op_sequencer
//  Description : Directed self-checking bench for alu_op_sequencer with a
//                behavioural model of the shared combinational ALU.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_op_sequencer;

   logic hz100;
   logic reset;
   int   n_checks;
   int   n_fail;
   int   n_ops;

   alu_op_sequencer_if #(.WIDTH(8)) bus ();

   alu_op_sequencer #(.WIDTH(8), .SETTLE_CYCLES(2)) u_dut (
      .hz100 (hz100),
      .reset (reset),
      .bus   (bus)
   );

   initial hz100 = 1'b0;
   always #5 hz100 = ~hz100;

   // Shared ALU model; distinctive values on illegal ops so a missing
   // zeroing of rsp_result is visible.
   always_comb begin
      case (bus.alu_opcode)
         4'b0001: bus.alu_result = {8'h00, bus.alu_a} + {8'h00, bus.alu_b};
         4'b0010: bus.alu_result = {8'h00, bus.alu_a} - {8'h00, bus.alu_b};
         4'b0011: bus.alu_result = (bus.alu_b == 8'h00) ? 16'hFFFF
                                   : {8'h00, bus.alu_a / bus.alu_b};
         4'b0100: bus.alu_result = {8'h00, bus.alu_a} * {8'h00, bus.alu_b};
         default: bus.alu_result = 16'hDEAD;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge hz100);
      #1;
   endtask

   task automatic drive_req(input logic [3:0] op, input logic [7:0] a,
                            input logic [7:0] b, input logic chain);
      bus.req_valid  = 1'b1;
      bus.req_opcode = op;
      bus.req_a      = a;
      bus.req_b      = b;
      bus.req_chain  = chain;
   endtask

   // Full-latency checked transaction.
   task automatic do_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic chain, input logic [7:0] exp_a,
                        input logic [15:0] exp_res, input logic exp_err);
      int k;
      k = 0;
      while (!bus.req_ready && k < 20) begin
         tick();
         k++;
      end
      chk({tag, " req_ready"}, bus.req_ready, 1);
      drive_req(op, a, b, chain);
      tick();                                   // E0
      bus.req_valid = 1'b0;
      chk({tag, " busy@E0"}, bus.busy, 1);
      chk({tag, " alu_a"}, bus.alu_a, exp_a);
      chk({tag, " valid@E0+1"}, bus.rsp_valid, 0);
      tick();                                   // E0+1
      chk({tag, " valid@E0+1b"}, bus.rsp_valid, 0);
      tick();                                   // E0+2
      chk({tag, " valid@E0+2"}, bus.rsp_valid, 1);
      chk({tag, " result"}, bus.rsp_result, exp_res);
      chk({tag, " err"}, bus.rsp_err, exp_err);
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      n_ops++;
      chk({tag, " valid_drop"}, bus.rsp_valid, 0);
      chk({tag, " ready_back"}, bus.req_ready, 1);
      chk({tag, " op_count"}, bus.op_count, 32'(n_ops[7:0]));
   endtask

   task automatic fast_op();
      int k;
      drive_req(4'b0001, 8'h01, 8'h01, 1'b0);
      tick();
      bus.req_valid = 1'b0;
      k = 0;
      while (!bus.rsp_valid && k < 20) begin
         tick();
         k++;
      end
      if (!bus.rsp_valid) chk("fast_op timeout", bus.rsp_valid, 1);
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      n_ops++;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit saw_valid;
      n_checks = 0;
      n_fail   = 0;
      n_ops    = 0;
      reset          = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_opcode = 4'd0;
      bus.req_a      = 8'd0;
      bus.req_b      = 8'd0;
      bus.req_chain  = 1'b0;
      bus.rsp_ready  = 1'b0;
      tick();
      tick();
      chk("rst req_ready", bus.req_ready, 1);
      chk("rst rsp_valid", bus.rsp_valid, 0);
      chk("rst busy", bus.busy, 0);
      chk("rst op_count", bus.op_count, 0);
      chk("rst alu_a", bus.alu_a, 0);
      chk("rst alu_opcode", bus.alu_opcode, 0);
      chk("rst rsp_result", bus.rsp_result, 0);
      chk("rst rsp_err", bus.rsp_err, 0);
      reset = 1'b0;
      tick();

      // Chain before any good result: A=0, req_a ignored.
      do_op("chain0", 4'b0001, 8'h55, 8'h07, 1'b1, 8'h00, 16'h0007, 1'b0);
      do_op("add",    4'b0001, 8'h12, 8'h34, 1'b0, 8'h12, 16'h0046, 1'b0);
      do_op("mul",    4'b0100, 8'hFF, 8'hFF, 1'b0, 8'hFF, 16'hFE01, 1'b0);
      do_op("chain",  4'b0001, 8'hAA, 8'h02, 1'b1, 8'h01, 16'h0003, 1'b0);
      do_op("div0",   4'b0011, 8'h10, 8'h00, 1'b0, 8'h10, 16'h0000, 1'b1);
      do_op("chain_after_err", 4'b0100, 8'h77, 8'h05, 1'b1, 8'h03, 16'h000F, 1'b0);
      do_op("bad_op", 4'b1111, 8'h01, 8'h01, 1'b0, 8'h01, 16'h0000, 1'b1);
      do_op("op0",    4'b0000, 8'h02, 8'h03, 1'b0, 8'h02, 16'h0000, 1'b1);
      do_op("div",    4'b0011, 8'h64, 8'h07, 1'b0, 8'h64, 16'h000E, 1'b0);
      tick();
      chk("hold alu_a", bus.alu_a, 8'h64);
      chk("hold alu_b", bus.alu_b, 8'h07);
      chk("hold alu_opcode", bus.alu_opcode, 4'b0011);

      // Backpressure with a competing request held by the requester.
      drive_req(4'b0001, 8'h01, 8'h02, 1'b0);
      tick();
      drive_req(4'b0010, 8'h09, 8'h04, 1'b0);
      tick();
      tick();
      for (int i = 0; i < 10; i++) begin
         chk("bp rsp_valid", bus.rsp_valid, 1);
         chk("bp rsp_result", bus.rsp_result, 16'h0003);
         chk("bp req_ready", bus.req_ready, 0);
         chk("bp alu_a", bus.alu_a, 8'h01);
         tick();
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      n_ops++;
      chk("bp done op_count", bus.op_count, 32'(n_ops[7:0]));
      chk("bp done busy", bus.busy, 0);

      // Reset during SETTLE discards the op.
      drive_req(4'b0001, 8'h20, 8'h20, 1'b0);
      tick();
      bus.req_valid = 1'b0;
      chk("settle busy", bus.busy, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_ops = 0;
      saw_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus.rsp_valid) saw_valid = 1'b1;
      end
      chk("rst_settle no_rsp", saw_valid, 0);
      chk("rst_settle req_ready", bus.req_ready, 1);
      chk("rst_settle op_count", bus.op_count, 0);

      // Reset coinciding with a request: not accepted.
      drive_req(4'b0100, 8'h03, 8'h03, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      bus.req_valid = 1'b0;
      chk("rst_req busy", bus.busy, 0);
      chk("rst_req alu_opcode", bus.alu_opcode, 0);
      tick();
      chk("rst_req still idle", bus.busy, 0);
      // last_result cleared: chained A must be 0.
      do_op("rst chain", 4'b0001, 8'hEE, 8'h09, 1'b1, 8'h00, 16'h0009, 1'b0);

      // Counter wrap.
      while (n_ops < 255) fast_op();
      chk("count 255", bus.op_count, 8'hFF);
      fast_op();
      chk("count wrap", bus.op_count, 8'h00);
      do_op("sub wrap", 4'b0010, 8'h03, 8'h05, 1'b0, 8'h03, 16'hFFFE, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
